// File: rtl/mcp_spi_master_if.sv
// ---------------------------------------------------------------------------
// mcp_spi_master_if
// Bundles the request/response handshake and the SPI pins of mcp_spi_master.
//   start, rw, reg_addr, wr_data : transaction request (processor side)
//   busy, done, rd_data          : transaction status / read result
//   spiClk, cs, mosi             : SPI outputs to the MCP23S17
//   miso                         : SPI input from the MCP23S17
// modport master : view of the SPI master itself
// modport slave  : view of whatever sits around it (processor + SPI device)
// ---------------------------------------------------------------------------
interface mcp_spi_master_if;
    logic       start;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       spiClk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, rw, reg_addr, wr_data, miso,
        output busy, done, rd_data, spiClk, cs, mosi
    );

    modport slave (
        output start, rw, reg_addr, wr_data, miso,
        input  busy, done, rd_data, spiClk, cs, mosi
    );
endinterface

// File: rtl/mcp_spi_master.sv
// ---------------------------------------------------------------------------
// mcp_spi_master
// SPI mode-0 master issuing one 3-byte MCP23S17 register transaction per
// start: {0100, HW_ADDR, rw} opcode, register address, data byte.
// spiClk is a slow strobe (CLK_DIV sysClk cycles per half period) so the
// slave's synchronizers see every edge.
//   sysClk : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : mcp_spi_master_if.master (request, status, SPI pins)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module mcp_spi_master #(
    parameter int         CLK_DIV = 4,
    parameter logic [2:0] HW_ADDR = 3'b000
) (
    input  logic              sysClk,
    input  logic              reset,
    mcp_spi_master_if.master  bus
);
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("mcp_spi_master: CLK_DIV must be within 2..255");
    end

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP, S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;      // half-period counter
    logic [4:0]  r_bit_cnt;  // 0..23, index of the bit currently on the wire
    logic        r_gap2;     // second half of the 2*CLK_DIV chip-select gap
    logic [22:0] r_tx;       // frame bits still to send; bit 23 goes out at load
    logic [7:0]  r_rx;
    logic        r_rw;
    logic        r_cs, r_sck, r_mosi, r_busy, r_done;
    logic [7:0]  r_rd_data;

    logic [23:0] w_frame;
    logic        w_last;

    // Reads shift out a zero data byte regardless of wr_data.
    assign w_frame = {4'b0100, HW_ADDR, bus.rw, bus.reg_addr,
                      bus.rw ? 8'h00 : bus.wr_data};
    assign w_last  = (r_cnt == DIV_M1);

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_bit_cnt <= 5'd0;
            r_gap2    <= 1'b0;
            r_tx      <= 23'd0;
            r_rx      <= 8'd0;
            r_rw      <= 1'b0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 5'd0;
                    r_cnt     <= 8'd0;
                    r_gap2    <= 1'b0;
                    if (bus.start) begin
                        r_tx    <= w_frame[22:0];
                        r_rw    <= bus.rw;
                        r_mosi  <= w_frame[23];
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_last) begin
                        r_cnt   <= 8'd0;
                        r_sck   <= 1'b1;
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_last) begin
                        // Sample at the end of the high phase; the slave has
                        // held miso stable since the preceding fall.
                        r_cnt   <= 8'd0;
                        r_rx    <= {r_rx[6:0], bus.miso};
                        r_sck   <= 1'b0;
                        r_mosi  <= r_tx[22];
                        r_tx    <= {r_tx[21:0], 1'b0};
                        r_state <= S_LOW;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_LOW: begin
                    if (w_last) begin
                        r_cnt <= 8'd0;
                        if (r_bit_cnt < 5'd23) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_sck     <= 1'b1;
                            r_state   <= S_HIGH;
                        end else begin
                            r_cs    <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    // 2*CLK_DIV may exceed 8 bits, so count two half periods.
                    if (w_last) begin
                        r_cnt <= 8'd0;
                        if (r_gap2) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            if (r_rw) r_rd_data <= r_rx;
                            r_state <= S_DONE;
                        end else begin
                            r_gap2 <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cs      = r_cs;
    assign bus.spiClk  = r_sck;
    assign bus.mosi    = r_mosi;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rd_data = r_rd_data;
endmodule

// File: doc/mcp_spi_master.md
# mcp_spi_master

SPI mode-0 master that issues single 3-byte MCP23S17 register transactions: opcode, register address, data. It sits between the processor-side I/O logic and the off-chip (or simulated) MCP23S17 SPI slave. It generates `cs`, `spiClk` and `mosi`, and captures the read byte from `miso`. The SPI clock is a slow divided strobe of `sysClk`, so the slave's 2-flop synchronizers can resolve every edge.

## Interface
- `CLK_DIV`, default 4: `sysClk` cycles per SPI half-period. Legal range 2..255; elaborate-time error outside that range.
- `HW_ADDR`, default 3'b000: MCP23S17 hardware address bits A2..A0, placed in the opcode.
- `sysClk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request. Sampled only while `busy`=0.
- `rw` input 1: 1 = register read, 0 = register write. Captured with `start`.
- `reg_addr` input 8: MCP23S17 register address. Captured with `start`.
- `wr_data` input 8: byte sent in the third byte slot. Captured with `start`; send 8'h00 on reads.
- `busy` output 1: high from the cycle after `start` until `done`.
- `done` output 1: one-cycle pulse at the end of the transaction.
- `rd_data` output 8: third received byte of the last read transaction.
- `spiClk` output 1: SPI clock, idle low.
- `cs` output 1: active-low chip select, idle high.
- `mosi` output 1: serial data out, MSB first.
- `miso` input 1: serial data in. Externally stable at `sysClk` level; no synchronizer inside.

## Operation
- Frame is the 24-bit value {4'b0100, HW_ADDR, rw, reg_addr, wr_data}, shifted MSB first.
- States and transitions:
  - IDLE: on `start`, load the shift register and go to SETUP.
  - SETUP: `cs`=0, `mosi`=frame[23]. Lasts CLK_DIV cycles, then go to HIGH.
  - HIGH: `spiClk`=1 for CLK_DIV cycles. On the last cycle, sample `miso` into rx shift register bit 0 and go to LOW.
  - LOW: `spiClk`=0. On entry, shift tx and drive the next bit on `mosi`. Lasts CLK_DIV cycles.
  - From LOW: if `bit_cnt` < 23, increment `bit_cnt` and go to HIGH; else go to GAP.
  - GAP: `cs`=1, `mosi`=0. Lasts 2*CLK_DIV cycles, then go to DONE.
  - DONE: one cycle. `done`=1; if the captured `rw`=1, load `rd_data` from the last 8 sampled bits. Return to IDLE.
- `bit_cnt` is 5 bits, counts 0..23, and clears in IDLE.
- The half-period counter is 8 bits. It reloads to 0 on every state change; the phase ends when count == CLK_DIV-1.
- `mosi` changes only in SETUP, on entry to LOW, and on entry to GAP. It is never changed while `spiClk`=1.
- Write transactions leave `rd_data` unchanged.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` in the DONE cycle is ignored. The earliest accepted `start` is the cycle after `done`.

## Timing
- Reset values, asserted asynchronously and immediately: `cs`=1, `spiClk`=0, `mosi`=0, `busy`=0, `done`=0, `rd_data`=8'h00, state IDLE.
- Reset mid-frame aborts the transaction with no `done` pulse.
- Accepting `start` at cycle 0 produces `busy`=1 and `cs`=0 at cycle 1.
- First `spiClk` rise occurs at cycle 1+CLK_DIV.
- 24 rising edges per frame, period 2*CLK_DIV cycles.
- Last `spiClk` fall is followed by CLK_DIV low cycles before `cs` rises.
- `cs` high for 2*CLK_DIV cycles before `done`.
- `done` at cycle 51*CLK_DIV + 1; `busy` falls in the same cycle.
- CLK_DIV=4 gives `done` at cycle 205.
- `rd_data` is valid in the `done` cycle and stays held until the next read's `done`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold `reset`=0 for 5 cycles, then release. Expect `cs`=1, `spiClk`=0, `mosi`=0, `busy`=0, `rd_data`=8'h00; no activity without `start`.
- Write: HW_ADDR=0, `rw`=0, `reg_addr`=8'h0A, `wr_data`=8'h5A, CLK_DIV=4. Expect 24 `spiClk` rises; bits captured on `mosi` at each rise = 24'h400A5A; `done` at cycle 205; `rd_data` unchanged.
- Read: `rw`=1, `reg_addr`=8'h12; bench slave drives 8'hE4 in byte 3, changing `miso` only on falling edges. Expect MOSI frame 24'h411200 and `rd_data`=8'hE4 in the `done` cycle.
- Back-to-back: assert `start` in the `done` cycle, then again the next cycle. Expect the first ignored and the second accepted, with `cs` held high for at least 2*CLK_DIV cycles between frames.
- Busy-ignore and abort: pulse `start` with different data at bit 10 of a frame; expect the frame unaltered. Then assert `reset` low at bit 15 of a new frame; expect `cs`=1, `spiClk`=0, `busy`=0 immediately and no `done` pulse.
- CLK_DIV=2: repeat the read test. Expect `done` at cycle 103 and `rd_data`=8'hE4.
